depthwise_conv_logic: RTL and testbench

Controller/datapath for the 3x3 depthwise convolution stage directly upstream of the pointwise stage. It reads an int8 input feature map, per-channel 3x3 kernels and biases from single-port BRAMs (1-cycle read latency). It requantises each result and writes the int8 depthwise output BRAM in channel-major layout (ch*HEIGHT*WIDTH + row*WIDTH + col), which the pointwise stage consumes.
Stride is 1 with zero padding of 1, so output dimensions equal input dimensions.

---
 rtl/depthwise_conv_logic.sv | 254 +++++++++++++++++++++++++
 tb/tb_depthwise_conv_logic.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/depthwise_conv_logic.sv
`default_nettype none
// ============================================================================
//  Module   : depthwise_conv_logic
//  Purpose  : 3x3 depthwise convolution controller/datapath (stride 1, zero
//             padding 1). Reads int8 activations, per-channel kernels and
//             biases from 1-cycle-latency BRAMs, requantises each result
//             (arithmetic shift + int8 saturation) and writes the output map
//             in channel-major order.
//  Options  : define DWCONV_RELU_EN to clamp negative results to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module depthwise_conv_logic #(
    parameter int CHANNELS     = 192,
    parameter int HEIGHT       = 28,
    parameter int WIDTH        = 32,
    parameter int DATA_WIDTH   = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int SHIFT        = 7,
    parameter int ADDR_WIDTH   = 18,
    parameter int W_ADDR_WIDTH = 11,
    parameter int B_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   in_bram_addr,
    input  logic [DATA_WIDTH-1:0]   in_bram_data,
    output logic [W_ADDR_WIDTH-1:0] w_bram_addr,
    input  logic [DATA_WIDTH-1:0]   w_bram_data,
    output logic [B_ADDR_WIDTH-1:0] bias_bram_addr,
    input  logic [BIAS_WIDTH-1:0]   bias_bram_data,
    output logic [ADDR_WIDTH-1:0]   out_bram_addr,
    output logic [DATA_WIDTH-1:0]   out_bram_data,
    output logic                    out_bram_we,
    output logic                    busy,
    output logic                    done
);

    localparam int CH_W  = $clog2(CHANNELS + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int PLANE = HEIGHT * WIDTH;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 <<< (DATA_WIDTH - 1)));

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BIAS_REQ  = 3'd1,
        S_BIAS_WAIT = 3'd2,
        S_TAP       = 3'd3,
        S_DRAIN     = 3'd4,
        S_WRITE     = 3'd5
    } state_t;

    state_t                   state_q;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [3:0]               tap_q, tap_d;
    logic [BIAS_WIDTH-1:0]    bias_q;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    // Issue stage: describes the tap whose addresses are on the BRAM ports.
    logic                     issue_q, issue_first_q, tap_valid_q;
    // Accumulate stage: the same tap one cycle later, aligned with BRAM data.
    logic                     acc_en_q, acc_first_q, acc_valid_q;
    logic [ADDR_WIDTH-1:0]    in_addr_q, out_addr_q;
    logic [W_ADDR_WIDTH-1:0]  w_addr_q;
    logic [B_ADDR_WIDTH-1:0]  b_addr_q;
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic                     out_we_q, busy_q, done_q;

    logic                     last_col, last_row, last_ch;
    int                       tap_row, tap_col;
    logic                     tap_inside;
    logic [ADDR_WIDTH-1:0]    in_addr_d;
    logic [W_ADDR_WIDTH-1:0]  w_addr_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, acc_base, shifted;
    logic [DATA_WIDTH-1:0]    sat_val;

    assign last_col = (col_q == COL_W'(WIDTH - 1));
    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    assign last_ch  = (ch_q  == CH_W'(CHANNELS - 1));

    // Next pixel/tap position: cleared on start, tap stepped in TAP, pixel advanced in WRITE.
    always_comb begin
        ch_d  = ch_q;
        row_d = row_q;
        col_d = col_q;
        tap_d = tap_q;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    ch_d  = '0;
                    row_d = '0;
                    col_d = '0;
                    tap_d = '0;
                end
            end
            S_BIAS_WAIT: tap_d = '0;
            S_TAP: begin
                if (tap_q != 4'd8) tap_d = tap_q + 4'd1;
            end
            S_WRITE: begin
                tap_d = '0;
                if (!last_col) begin
                    col_d = col_q + COL_W'(1);
                end else begin
                    col_d = '0;
                    if (!last_row) begin
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        row_d = '0;
                        if (!last_ch) ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Read addresses for the tap about to be issued; padded taps read address 0.
    always_comb begin
        tap_row    = int'(row_d) + int'(tap_d) / 3 - 1;
        tap_col    = int'(col_d) + int'(tap_d) % 3 - 1;
        tap_inside = (tap_row >= 0) && (tap_row < HEIGHT) && (tap_col >= 0) && (tap_col < WIDTH);
        in_addr_d  = tap_inside ? ADDR_WIDTH'(int'(ch_d) * PLANE + tap_row * WIDTH + tap_col) : '0;
        w_addr_d   = W_ADDR_WIDTH'(int'(ch_d) * 9 + int'(tap_d));
    end

    assign prod     = $signed(in_bram_data) * $signed(w_bram_data);
    assign prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};

    // MAC: first tap of a pixel reloads from the bias, padded taps add nothing; then requantise.
    always_comb begin
        acc_base = acc_first_q ? bias_ext : acc_q;
        acc_d    = acc_en_q ? (acc_base + (acc_valid_q ? prod_ext : '0)) : acc_q;
        shifted  = acc_d >>> SHIFT;
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_WIDTH-1:0];
        else                        sat_val = shifted[DATA_WIDTH-1:0];
`ifdef DWCONV_RELU_EN
        if (sat_val[DATA_WIDTH-1]) sat_val = '0;
`else
`endif
    end

    // Control FSM with registered BRAM addresses, write port and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            tap_q         <= '0;
            bias_q        <= '0;
            acc_q         <= '0;
            issue_q       <= 1'b0;
            issue_first_q <= 1'b0;
            tap_valid_q   <= 1'b0;
            acc_en_q      <= 1'b0;
            acc_first_q   <= 1'b0;
            acc_valid_q   <= 1'b0;
            in_addr_q     <= '0;
            w_addr_q      <= '0;
            b_addr_q      <= '0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            acc_en_q    <= issue_q;
            acc_first_q <= issue_first_q;
            acc_valid_q <= tap_valid_q;
            issue_q     <= 1'b0;
            out_we_q    <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !done_q) begin
                        state_q  <= S_BIAS_REQ;
                        busy_q   <= 1'b1;
                        b_addr_q <= B_ADDR_WIDTH'(ch_d);
                    end
                end
                S_BIAS_REQ: state_q <= S_BIAS_WAIT;
                S_BIAS_WAIT: begin
                    bias_q        <= bias_bram_data;
                    state_q       <= S_TAP;
                    in_addr_q     <= in_addr_d;
                    w_addr_q      <= w_addr_d;
                    tap_valid_q   <= tap_inside;
                    issue_q       <= 1'b1;
                    issue_first_q <= 1'b1;
                end
                S_TAP: begin
                    if (tap_q == 4'd8) begin
                        state_q <= S_DRAIN;
                    end else begin
                        in_addr_q     <= in_addr_d;
                        w_addr_q      <= w_addr_d;
                        tap_valid_q   <= tap_inside;
                        issue_q       <= 1'b1;
                        issue_first_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    state_q    <= S_WRITE;
                    out_data_q <= sat_val;
                    out_addr_q <= ADDR_WIDTH'(int'(ch_q) * PLANE + int'(row_q) * WIDTH + int'(col_q));
                    out_we_q   <= 1'b1;
                end
                S_WRITE: begin
                    if (last_col && last_row && last_ch) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (last_col && last_row) begin
                        state_q  <= S_BIAS_REQ;
                        b_addr_q <= B_ADDR_WIDTH'(ch_d);
                    end else begin
                        state_q       <= S_TAP;
                        in_addr_q     <= in_addr_d;
                        w_addr_q      <= w_addr_d;
                        tap_valid_q   <= tap_inside;
                        issue_q       <= 1'b1;
                        issue_first_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_bram_addr   = in_addr_q;
    assign w_bram_addr    = w_addr_q;
    assign bias_bram_addr = b_addr_q;
    assign out_bram_addr  = out_addr_q;
    assign out_bram_data  = out_data_q;
    assign out_bram_we    = out_we_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_depthwise_conv_logic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_depthwise_conv_logic
//  Purpose  : Self-checking bench for depthwise_conv_logic (2 channels, 4x4,
//             SHIFT=1). Behavioural BRAMs, reference model and write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_depthwise_conv_logic;

    localparam int CH       = 2;
    localparam int H        = 4;
    localparam int W        = 4;
    localparam int SH       = 1;
    localparam int PLANE    = H * W;
    localparam int DONE_CYC = CH * (2 + 11 * PLANE) + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [17:0] in_bram_addr;
    logic [7:0]  in_bram_data;
    logic [10:0] w_bram_addr;
    logic [7:0]  w_bram_data;
    logic [7:0]  bias_bram_addr;
    logic [15:0] bias_bram_data;
    logic [17:0] out_bram_addr;
    logic [7:0]  out_bram_data;
    logic        out_bram_we;
    logic        busy;
    logic        done;

    logic signed [7:0]  in_mem [CH*PLANE];
    logic signed [7:0]  w_mem  [CH*9];
    logic signed [15:0] b_mem  [CH];

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];

    depthwise_conv_logic #(
        .CHANNELS(CH), .HEIGHT(H), .WIDTH(W), .DATA_WIDTH(8), .BIAS_WIDTH(16),
        .ACC_WIDTH(32), .SHIFT(SH), .ADDR_WIDTH(18), .W_ADDR_WIDTH(11), .B_ADDR_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_bram_addr(in_bram_addr), .in_bram_data(in_bram_data),
        .w_bram_addr(w_bram_addr), .w_bram_data(w_bram_data),
        .bias_bram_addr(bias_bram_addr), .bias_bram_data(bias_bram_data),
        .out_bram_addr(out_bram_addr), .out_bram_data(out_bram_data),
        .out_bram_we(out_bram_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Single-port BRAMs with one cycle of read latency.
    always @(posedge clk) begin
        in_bram_data   <= (int'(in_bram_addr) < CH*PLANE) ? in_mem[int'(in_bram_addr)] : 8'h00;
        w_bram_data    <= (int'(w_bram_addr) < CH*9) ? w_mem[int'(w_bram_addr)] : 8'h00;
        bias_bram_data <= (int'(bias_bram_addr) < CH) ? b_mem[int'(bias_bram_addr)] : 16'h0000;
    end

    function automatic logic [7:0] model_px(input int ch, input int r, input int c);
        int acc, rr, cc, res;
        acc = b_mem[ch];
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                rr = r + ky - 1;
                cc = c + kx - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    acc += int'(in_mem[ch*PLANE + rr*W + cc]) * int'(w_mem[ch*9 + ky*3 + kx]);
            end
        end
        res = acc >>> SH;
        if (res > 127)  res = 127;
        if (res < -128) res = -128;
`ifdef DWCONV_RELU_EN
        if (res < 0) res = 0;
`endif
        return res[7:0];
    endfunction

    task automatic fill_const(input int iv, input int wv0, input int wv1, input int b0, input int b1);
        for (int i = 0; i < CH*PLANE; i++) in_mem[i] = 8'(iv);
        for (int i = 0; i < CH*9; i++)     w_mem[i]  = (i < 9) ? 8'(wv0) : 8'(wv1);
        b_mem[0] = 16'(b0);
        b_mem[1] = 16'(b1);
    endtask

    task automatic push_expected();
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    exp_addr_q.push_back(18'(ch*PLANE + r*W + c));
                    exp_data_q.push_back(model_px(ch, r, c));
                end
    endtask

    task automatic kick();
        push_expected();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Runs until done (or a cycle budget), checking every write against the scoreboard.
    task automatic collect(input bit inject, input string tag);
        int cyc = 0;
        bit seen_done = 1'b0;
        logic [17:0] ea;
        logic [7:0]  ed;
        while (!seen_done && cyc < DONE_CYC + 20) begin
            @(negedge clk);
            cyc++;
            start = (inject && cyc == 50);
            if (cyc == 1) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got=%b want=1", tag, busy); end
            end
            if (out_bram_we === 1'b1) begin
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected_write: addr=%0d data=%0d", tag, out_bram_addr, $signed(out_bram_data));
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (out_bram_addr !== ea || out_bram_data !== ed) begin
                        bad++;
                        $display("FAIL %s write: got addr=%0d data=%0d want addr=%0d data=%0d",
                                 tag, out_bram_addr, $signed(out_bram_data), ea, $signed(ed));
                    end
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                total++;
                if (cyc != DONE_CYC) begin bad++; $display("FAIL %s done_latency: got=%0d want=%0d", tag, cyc, DONE_CYC); end
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got=%b want=0", tag, busy); end
                total++;
                if (exp_addr_q.size() != 0) begin bad++; $display("FAIL %s missing_writes: got=%0d left want=0", tag, exp_addr_q.size()); end
            end
        end
        if (!seen_done) begin
            total++;
            bad++;
            $display("FAIL %s done_timeout: got no done in %0d cycles want done at %0d", tag, cyc, DONE_CYC);
        end
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done: got=%b want=0", done); end
        total++; if (out_bram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got=%b want=0", out_bram_we); end
        total++; if (in_bram_addr !== 18'd0 || w_bram_addr !== 11'd0 || bias_bram_addr !== 8'd0)
            begin bad++; $display("FAIL reset_rd_addr: got in=%0d w=%0d b=%0d want 0", in_bram_addr, w_bram_addr, bias_bram_addr); end
        total++; if (out_bram_addr !== 18'd0 || out_bram_data !== 8'd0)
            begin bad++; $display("FAIL reset_out: got addr=%0d data=%0d want 0", out_bram_addr, out_bram_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // All ones, zero bias: corners 4, edges 6, interior 9 before the shift.
    task automatic test_all_ones();
        fill_const(1, 1, 1, 0, 0);
        kick();
        collect(1'b0, "all_ones");
    endtask

    // Bias -10: corner (4-10)>>>1 = -3, exercising floor rounding of negatives.
    task automatic test_neg_bias();
        fill_const(1, 1, 1, -10, -10);
        kick();
        collect(1'b0, "neg_bias");
    endtask

    task automatic test_saturation();
        fill_const(127, 127, 127, 0, 0);
        kick();
        collect(1'b0, "sat_pos");
        fill_const(127, -127, -127, 0, 0);
        kick();
        collect(1'b0, "sat_neg");
    endtask

    // Distinct per-channel kernels and biases with small mixed-sign data.
    task automatic test_two_channel();
        for (int i = 0; i < CH*PLANE; i++) in_mem[i] = 8'($urandom_range(0, 12)) - 8'sd6;
        for (int i = 0; i < CH*9; i++)     w_mem[i]  = 8'($urandom_range(0, 12)) - 8'sd6;
        b_mem[0] = 16'sd37;
        b_mem[1] = -16'sd45;
        kick();
        collect(1'b0, "two_channel");
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL midreset_busy: got=%b want=0", busy); end
        total++; if (out_bram_we !== 1'b0) begin bad++; $display("FAIL midreset_we: got=%b want=0", out_bram_we); end
        repeat (40) begin
            @(negedge clk);
            if (out_bram_we === 1'b1 || busy === 1'b1) writes++;
        end
        total++; if (writes != 0) begin bad++; $display("FAIL midreset_activity: got=%0d active cycles want=0", writes); end
        kick();
        collect(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        kick();
        collect(1'b1, "busy_start");
        // Still in the done cycle: this start must be ignored, the next one accepted.
        start = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single_pulse: got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_on_done_ignored: got busy=%b want=0", busy); end
        push_expected();
        collect(1'b0, "restart");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_all_ones();
        test_neg_bias();
        test_saturation();
        test_two_channel();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
